// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master between NREQ clients: latches the
// winner's command, pulses the master enable, then tracks busy/dvalid to completion.
module i2c_txn_arbiter #(
  parameter int NREQ     = 2,
  parameter int START_TO = 15
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   rw_i,
  input  logic [NREQ-1:0]   ur_i,
  input  logic [7*NREQ-1:0] devadr_i,
  input  logic [8*NREQ-1:0] regadr_i,
  input  logic [8*NREQ-1:0] wdat_i,
  input  logic [16*NREQ-1:0] datnum_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [7:0]        rdat_o,
  output logic [NREQ-1:0]   rvalid_o,
  output logic [NREQ-1:0]   done_o,
  output logic [NREQ-1:0]   err_o,
  output logic              m_enable_o,
  output logic              m_rw_o,
  output logic              m_ur_o,
  output logic [6:0]        m_devadr_o,
  output logic [7:0]        m_regadr_o,
  output logic [7:0]        m_dat_o,
  output logic [15:0]       m_datnum_o,
  input  logic              m_busy_i,
  input  logic              m_dvalid_i,
  input  logic [7:0]        m_dat_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {ARB, LAUNCH, WAIT_BUSY, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   rr_ptr, gnt_idx, pick_idx;
  logic [NREQ-1:0] pick_onehot;
  logic            pick_valid;
  logic [3:0]      start_cnt;
  logic            start_expired;
  logic            timeout;
  logic [15:0]     byte_cnt;
  logic [15:0]     want_cnt;
  logic            txn_err;

  logic [6:0]  dev_arr [NREQ];
  logic [7:0]  reg_arr [NREQ];
  logic [7:0]  wd_arr  [NREQ];
  logic [15:0] dn_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign dev_arr[gi] = devadr_i[7*gi +: 7];
    assign reg_arr[gi] = regadr_i[8*gi +: 8];
    assign wd_arr[gi]  = wdat_i[8*gi +: 8];
    assign dn_arr[gi]  = datnum_i[16*gi +: 16];
  end

  // First requester at or above the rr pointer, wrapping around.
  always_comb begin
    int k;
    k           = 0;
    pick_valid  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!pick_valid && req_i[k]) begin
        pick_valid     = 1'b1;
        pick_idx       = IW'(k);
        pick_onehot[k] = 1'b1;
      end
    end
  end

  assign start_expired = (start_cnt == 4'(START_TO - 1));
  assign want_cnt      = (m_datnum_o == 16'd0) ? 16'd1 : m_datnum_o;
  assign txn_err       = timeout | (m_rw_o & (byte_cnt != want_cnt));

  assign m_enable_o = (state == LAUNCH);
  assign done_o     = (state == DONE) ? gnt_o : '0;
  assign err_o      = (state == DONE && txn_err) ? gnt_o : '0;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= ARB;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB:       if (pick_valid) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (m_busy_i)           state_next = RUN;
        else if (start_expired) state_next = DONE;
      end
      RUN:       if (!m_busy_i) state_next = DONE;
      DONE:      state_next = ARB;
      default:   state_next = ARB;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      gnt_o      <= '0;
      rdat_o     <= '0;
      rvalid_o   <= '0;
      m_rw_o     <= 1'b0;
      m_ur_o     <= 1'b0;
      m_devadr_o <= '0;
      m_regadr_o <= '0;
      m_dat_o    <= '0;
      m_datnum_o <= '0;
      start_cnt  <= '0;
      timeout    <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      rvalid_o <= '0;
      case (state)
        ARB: begin
          if (pick_valid) begin
            gnt_idx    <= pick_idx;
            gnt_o      <= pick_onehot;
            m_rw_o     <= rw_i[pick_idx];
            m_ur_o     <= ur_i[pick_idx];
            m_devadr_o <= dev_arr[pick_idx];
            m_regadr_o <= reg_arr[pick_idx];
            m_dat_o    <= wd_arr[pick_idx];
            m_datnum_o <= dn_arr[pick_idx];
          end
        end
        LAUNCH: begin
          start_cnt <= '0;
          timeout   <= 1'b0;
          byte_cnt  <= '0;
        end
        WAIT_BUSY: begin
          if (!m_busy_i) begin
            if (start_expired) timeout <= 1'b1;
            else               start_cnt <= start_cnt + 4'd1;
          end
        end
        RUN: begin
          // dvalid is meaningless on writes, so only reads produce bytes.
          if (m_rw_o && m_dvalid_i) begin
            rvalid_o <= gnt_o;
            rdat_o   <= m_dat_i;
            byte_cnt <= byte_cnt + 16'd1;
          end
        end
        DONE: begin
          gnt_o  <= '0;
          rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench: table-driven rows, randomized transactions against a
// round-robin/byte-count reference model, and a reset-during-RUN sequence.
module tb_i2c_txn_arbiter;
  localparam int NREQ     = 2;
  localparam int START_TO = 15;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [1:0]    req_i = '0, rw_i = '0, ur_i = '0;
  logic [13:0]   devadr_i = '0;
  logic [15:0]   regadr_i = '0, wdat_i = '0;
  logic [31:0]   datnum_i = '0;
  logic [1:0]    gnt_o, rvalid_o, done_o, err_o;
  logic [7:0]    rdat_o;
  logic          m_enable_o, m_rw_o, m_ur_o;
  logic [6:0]    m_devadr_o;
  logic [7:0]    m_regadr_o, m_dat_o;
  logic [15:0]   m_datnum_o;
  logic          m_busy_i = 1'b0, m_dvalid_i = 1'b0;
  logic [7:0]    m_dat_i = '0;

  i2c_txn_arbiter #(.NREQ(NREQ), .START_TO(START_TO)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .req_i(req_i), .rw_i(rw_i), .ur_i(ur_i),
    .devadr_i(devadr_i), .regadr_i(regadr_i), .wdat_i(wdat_i), .datnum_i(datnum_i),
    .gnt_o(gnt_o), .rdat_o(rdat_o), .rvalid_o(rvalid_o), .done_o(done_o), .err_o(err_o),
    .m_enable_o(m_enable_o), .m_rw_o(m_rw_o), .m_ur_o(m_ur_o), .m_devadr_o(m_devadr_o),
    .m_regadr_o(m_regadr_o), .m_dat_o(m_dat_o), .m_datnum_o(m_datnum_o),
    .m_busy_i(m_busy_i), .m_dvalid_i(m_dvalid_i), .m_dat_i(m_dat_i)
  );

  always #5 clock_i = ~clock_i;

  int errors = 0;
  int checks = 0;
  int rr_m   = 0;

  typedef struct {
    logic [1:0]       req;
    logic [1:0]       rw, ur;
    logic [1:0][6:0]  dev;
    logic [1:0][7:0]  rga, wd;
    logic [1:0][15:0] dn;
    int               dly;     // clocks after enable before the master raises busy
    int               nb;      // bytes the master delivers (dvalid pulses)
    logic [7:0][7:0]  bytes;
    int               exp_g;
    bit               exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] req, input int g, input bit rw, input bit ur,
                              input logic [6:0] dev, input logic [7:0] rga, input logic [7:0] wd,
                              input logic [15:0] dn, input int dly, input int nb,
                              input logic [63:0] b, input bit ee);
    vec_t v;
    v.req = req;
    v.rw[g] = rw;    v.rw[1-g] = ~rw;
    v.ur[g] = ur;    v.ur[1-g] = ~ur;
    v.dev[g] = dev;  v.dev[1-g] = ~dev;
    v.rga[g] = rga;  v.rga[1-g] = ~rga;
    v.wd[g] = wd;    v.wd[1-g] = ~wd;
    v.dn[g] = dn;    v.dn[1-g] = dn + 16'd1;
    v.dly = dly; v.nb = nb; v.bytes = b; v.exp_g = g; v.exp_err = ee;
    return v;
  endfunction

  // Reference: round-robin pick from the pointer, and the completion error rule.
  function automatic int model_pick(input logic [1:0] req, input int rr);
    for (int i = 0; i < NREQ; i++)
      if (req[(rr + i) % NREQ]) return (rr + i) % NREQ;
    return -1;
  endfunction

  function automatic bit model_err(input vec_t v);
    int want;
    want = (v.dn[v.exp_g] == 16'd0) ? 1 : int'(v.dn[v.exp_g]);
    if (v.dly > START_TO) return 1'b1;
    return v.rw[v.exp_g] && (v.nb != want);
  endfunction

  task automatic run_txn(input vec_t v);
    int g, en_t, en_cnt, t, lat, nexp, exp_lat, gnt_bad, stab_bad, idx;
    bit done_seen;
    logic [1:0] ohot, done_v, err_v;
    logic [40:0] snap;
    logic [7:0] got[$];
    g = v.exp_g;
    ohot = 2'b01 << g;
    req_i = v.req; rw_i = v.rw; ur_i = v.ur;
    devadr_i = v.dev; regadr_i = v.rga; wdat_i = v.wd; datnum_i = v.dn;
    en_t = -1; en_cnt = 0; lat = -1; gnt_bad = 0; stab_bad = 0; done_seen = 0;
    done_v = '0; err_v = '0; snap = '0;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      @(negedge clock_i);
      t = (en_t >= 0) ? c - en_t : -1;
      if (gnt_o !== ohot) gnt_bad++;
      if (en_t >= 0 && snap !== {m_rw_o, m_ur_o, m_devadr_o, m_regadr_o, m_dat_o, m_datnum_o})
        stab_bad++;
      if (m_enable_o) begin
        en_cnt++;
        if (en_t < 0) begin
          en_t = c; t = 0;
          chk("m_devadr", m_devadr_o, v.dev[g]);
          chk("m_regadr", m_regadr_o, v.rga[g]);
          chk("m_dat",    m_dat_o,    v.wd[g]);
          chk("m_datnum", m_datnum_o, v.dn[g]);
          chk("m_rw_ur",  {m_rw_o, m_ur_o}, {v.rw[g], v.ur[g]});
          snap = {m_rw_o, m_ur_o, m_devadr_o, m_regadr_o, m_dat_o, m_datnum_o};
          // Client side is free to change once latched, including dropping req.
          req_i = 2'($urandom); devadr_i = 14'($urandom); datnum_i = $urandom;
          rw_i = 2'($urandom); wdat_i = 16'($urandom);
        end
      end
      if (rvalid_o != '0) begin
        chk("rvalid_dst", rvalid_o, ohot);
        got.push_back(rdat_o);
      end
      if (done_o != '0) begin
        done_seen = 1; done_v = done_o; err_v = err_o; lat = t;
      end
      m_busy_i = 1'b0; m_dvalid_i = 1'b0; m_dat_i = 8'($urandom);
      if (en_t >= 0 && !done_seen) begin
        m_busy_i   = (t >= v.dly) && (t < v.dly + 1 + v.nb);
        m_dvalid_i = (t >= v.dly + 1) && (t <= v.dly + v.nb);
        idx = t - v.dly - 1;
        if (m_dvalid_i && idx >= 0 && idx < 8) m_dat_i = v.bytes[idx];
      end
    end
    m_busy_i = 1'b0; m_dvalid_i = 1'b0;
    nexp    = (v.dly <= START_TO && v.rw[g]) ? v.nb : 0;
    exp_lat = (v.dly > START_TO) ? START_TO + 1 : v.dly + v.nb + 2;
    chk("done_seen", done_seen, 1'b1);
    chk("done_dst", done_v, ohot);
    chk("err", err_v, v.exp_err ? ohot : 2'b00);
    chk("enable_pulses", en_cnt, 1);
    chk("done_latency", lat, exp_lat);
    chk("gnt_held", gnt_bad, 0);
    chk("cmd_stable", stab_bad, 0);
    chk("rbyte_count", got.size(), nexp);
    for (int i = 0; i < got.size() && i < nexp; i++) chk("rbyte", got[i], v.bytes[i]);
    @(negedge clock_i);
    chk("gnt_clear", gnt_o, 2'b00);
    chk("done_pulse", done_o, 2'b00);
    $display("txn req=%b gnt=%0d rw=%0b dn=%0d dly=%0d nb=%0d err=%b bytes=%0d",
             v.req, g, v.rw[g], v.dn[g], v.dly, v.nb, err_v, got.size());
    rr_m = (g + 1) % NREQ;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = mk(2'b01, 0, 0, 0, 7'h50, 8'h10, 8'hA5, 16'd1, 2, 0, 64'h0, 0);
    tbl[1] = mk(2'b01, 0, 1, 1, 7'h48, 8'h20, 8'h00, 16'd3, 3, 3, 64'h332211, 0);
    tbl[2] = mk(2'b11, 1, 0, 0, 7'h3C, 8'h05, 8'h99, 16'd1, 99, 0, 64'h0, 1);
    tbl[3] = mk(2'b11, 0, 0, 0, 7'h51, 8'h11, 8'h5A, 16'd1, 1, 0, 64'h0, 0);
    tbl[4] = mk(2'b10, 1, 1, 1, 7'h68, 8'h3B, 8'h00, 16'd4, 2, 1, 64'hC3, 1);
    tbl[5] = mk(2'b01, 0, 1, 0, 7'h1A, 8'h44, 8'h00, 16'd0, START_TO, 1, 64'hE7, 0);
    tbl[6] = mk(2'b10, 1, 0, 0, 7'h2B, 8'h55, 8'h3C, 16'd2, 3, 2, 64'hBEEF, 0);
    tbl[7] = mk(2'b11, 0, 1, 0, 7'h77, 8'h66, 8'h00, 16'd1, 1, 2, 64'h0102, 1);
    tbl[8] = mk(2'b10, 1, 0, 1, 7'h0F, 8'h77, 8'h81, 16'd5, 4, 0, 64'h0, 0);

    @(negedge clock_i);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_enable", m_enable_o, 1'b0);
    chk("rst_outs", {rvalid_o, done_o, err_o, rdat_o}, 0);
    chk("rst_cmd", {m_rw_o, m_ur_o, m_devadr_o, m_regadr_o, m_dat_o, m_datnum_o}, 0);
    reset_i = 1'b0;
    @(negedge clock_i);
    chk("idle_no_gnt", gnt_o, 2'b00);

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    for (int n = 0; n < 24; n++) begin
      vec_t v;
      logic [1:0] req;
      int g, want, nb, dly;
      bit rw;
      logic [15:0] dn;
      req  = (n < 4) ? 2'b11 : 2'($urandom_range(1, 3));
      g    = model_pick(req, rr_m);
      rw   = 1'($urandom);
      dn   = 16'($urandom_range(0, 4));
      want = (dn == 16'd0) ? 1 : int'(dn);
      nb   = rw ? ($urandom_range(0, 1) ? want : int'($urandom_range(0, 5))) : int'($urandom_range(0, 3));
      dly  = ($urandom_range(0, 5) == 0) ? 99 : int'($urandom_range(1, START_TO));
      v = mk(req, g, rw, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), dn,
             dly, nb, {$urandom, $urandom}, 0);
      v.exp_err = model_err(v);
      run_txn(v);
    end

    // Reset during RUN: client 1 is mid-read when reset hits.
    run_txn(mk(2'b01, 0, 0, 0, 7'h21, 8'h01, 8'h5A, 16'd1, 2, 0, 64'h0, 0));
    req_i = 2'b11; rw_i = 2'b10; datnum_i = {16'd4, 16'd1}; devadr_i = {7'h33, 7'h22};
    begin
      bit seen;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clock_i);
        if (m_enable_o) seen = 1;
      end
      chk("rst_launch", seen, 1'b1);
    end
    m_busy_i = 1'b1;
    @(negedge clock_i);
    @(negedge clock_i);
    m_dvalid_i = 1'b1; m_dat_i = 8'h77;
    @(negedge clock_i);
    chk("pre_rst_gnt", gnt_o, 2'b10);
    chk("pre_rst_rvalid", rvalid_o, 2'b10);
    #2 reset_i = 1'b1;
    #1;
    chk("mid_rst_gnt", gnt_o, 2'b00);
    chk("mid_rst_outs", {m_enable_o, rvalid_o, done_o, err_o, rdat_o}, 0);
    chk("mid_rst_cmd", {m_rw_o, m_devadr_o, m_datnum_o}, 0);
    m_busy_i = 1'b0; m_dvalid_i = 1'b0;
    @(negedge clock_i);
    reset_i = 1'b0;
    rr_m = 0;
    run_txn(mk(2'b11, model_pick(2'b11, rr_m), 0, 0, 7'h42, 8'h24, 8'h18, 16'd1, 1, 0, 64'h0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
